// File: rtl/jtag_scan_seq_if.sv
// Scan-request / scan-response / TAP-pin bundle for jtag_scan_seq.
// master: requester plus TAP side (drives REQ_* and SEQ_TDO, observes the rest).
// slave:  the sequencer (drives REQ_READY, SEQ_TMS, SEQ_TDI, RSP_*, SEQ_BUSY).
interface jtag_scan_seq_if;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic [4:0]  REQ_IR;
   logic        REQ_SKIP_IR;
   logic [5:0]  REQ_DR_LEN;
   logic [31:0] REQ_DR_DATA;
   logic        SEQ_TMS;
   logic        SEQ_TDI;
   logic        SEQ_TDO;
   logic        RSP_VALID;
   logic [31:0] RSP_DATA;
   logic        SEQ_BUSY;

   modport master (
      output REQ_VALID, REQ_IR, REQ_SKIP_IR, REQ_DR_LEN, REQ_DR_DATA, SEQ_TDO,
      input  REQ_READY, SEQ_TMS, SEQ_TDI, RSP_VALID, RSP_DATA, SEQ_BUSY
   );

   modport slave (
      input  REQ_VALID, REQ_IR, REQ_SKIP_IR, REQ_DR_LEN, REQ_DR_DATA, SEQ_TDO,
      output REQ_READY, SEQ_TMS, SEQ_TDI, RSP_VALID, RSP_DATA, SEQ_BUSY
   );
endinterface

// File: rtl/jtag_scan_seq.sv
// JTAG scan sequencer: walks the TAP through an optional 5-bit IR scan and a 1..32 bit DR scan.
// Latency: acceptance edge to RSP_VALID cycle is 15+len cycles (IR+DR) or 5+len (DR only).
// Backpressure: REQ_READY only in IDLE; REQ_* ignored while SEQ_BUSY. Optional TDO capture: JTAG_SEQ_TDO_CAPTURE_EN.
// Ports: JTAG_CLOCK, reset_N (async active-low), bus (jtag_scan_seq_if.slave: request, response, TAP pins).
module jtag_scan_seq (
   input  logic            JTAG_CLOCK,
   input  logic            reset_N,
   jtag_scan_seq_if.slave  bus
);

   // Each state mirrors the TAP state the TAP occupies in the same cycle
   // (GO is Run-Test/Idle with TMS=1 to leave it).
   typedef enum logic [3:0] {
      ST_INIT, ST_IDLE, ST_GO, ST_SEL_DR, ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR,
      ST_EXIT_IR, ST_UPD_IR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT_DR, ST_UPD_DR
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  ir_sh_q, ir_sh_d;
   logic [31:0] dr_sh_q, dr_sh_d;
   logic [4:0]  len_m1_q, len_m1_d;
   // Set when the next Select-DR visit must go to Capture-DR
   // (IR scan skipped, or already done).
   logic        dr_next_q, dr_next_d;
   logic        rsp_vld_q, rsp_vld_d;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
   logic [31:0] rsp_dat_q, rsp_dat_d;
`endif
   logic        seq_tms;
   logic        seq_tdi;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ir_sh_d   = ir_sh_q;
      dr_sh_d   = dr_sh_q;
      len_m1_d  = len_m1_q;
      dr_next_d = dr_next_q;
      rsp_vld_d = 1'b0;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
      rsp_dat_d = rsp_dat_q;
`endif
      case (state_q)
         ST_INIT: begin
            if (cnt_q == 5'd5) begin
               state_d = ST_IDLE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_IDLE: begin
            if (bus.REQ_VALID) begin
               state_d   = ST_GO;
               cnt_d     = 5'd0;
               ir_sh_d   = bus.REQ_IR;
               dr_sh_d   = bus.REQ_DR_DATA;
               dr_next_d = bus.REQ_SKIP_IR;
               // Length 0 and anything from 32 up both mean a full 32-bit scan.
               if (bus.REQ_DR_LEN == 6'd0 || bus.REQ_DR_LEN >= 6'd32)
                  len_m1_d = 5'd31;
               else
                  len_m1_d = bus.REQ_DR_LEN[4:0] - 5'd1;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
               rsp_dat_d = '0;
`endif
            end
         end
         ST_GO:       state_d = ST_SEL_DR;
         ST_SEL_DR:   state_d = dr_next_q ? ST_CAP_DR : ST_SEL_IR;
         ST_SEL_IR:   state_d = ST_CAP_IR;
         ST_CAP_IR: begin
            state_d = ST_SHIFT_IR;
            cnt_d   = 5'd0;
         end
         ST_SHIFT_IR: begin
            ir_sh_d = {1'b0, ir_sh_q[4:1]};
            if (cnt_q == 5'd4) begin
               state_d = ST_EXIT_IR;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_EXIT_IR:  state_d = ST_UPD_IR;
         ST_UPD_IR: begin
            state_d   = ST_SEL_DR;
            dr_next_d = 1'b1;
         end
         ST_CAP_DR: begin
            state_d = ST_SHIFT_DR;
            cnt_d   = 5'd0;
         end
         ST_SHIFT_DR: begin
            dr_sh_d = {1'b0, dr_sh_q[31:1]};
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
            rsp_dat_d[cnt_q] = bus.SEQ_TDO;
`endif
            if (cnt_q == len_m1_q) begin
               state_d = ST_EXIT_DR;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_EXIT_DR:  state_d = ST_UPD_DR;
         ST_UPD_DR: begin
            state_d   = ST_IDLE;
            rsp_vld_d = 1'b1;
         end
         default:     state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge JTAG_CLOCK or negedge reset_N) begin
      if (!reset_N) begin
         state_q   <= ST_INIT;
         cnt_q     <= 5'd0;
         ir_sh_q   <= 5'd0;
         dr_sh_q   <= 32'd0;
         len_m1_q  <= 5'd0;
         dr_next_q <= 1'b0;
         rsp_vld_q <= 1'b0;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
         rsp_dat_q <= 32'd0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ir_sh_q   <= ir_sh_d;
         dr_sh_q   <= dr_sh_d;
         len_m1_q  <= len_m1_d;
         dr_next_q <= dr_next_d;
         rsp_vld_q <= rsp_vld_d;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
         rsp_dat_q <= rsp_dat_d;
`endif
      end
   end

   // TMS/TDI come only from registered state so the TAP pins never see REQ_* glitches.
   always_comb begin
      seq_tms = 1'b0;
      seq_tdi = 1'b0;
      case (state_q)
         ST_INIT:     seq_tms = (cnt_q != 5'd5);
         ST_GO:       seq_tms = 1'b1;
         ST_SEL_DR:   seq_tms = ~dr_next_q;
         ST_SHIFT_IR: begin
            seq_tms = (cnt_q == 5'd4);
            seq_tdi = ir_sh_q[0];
         end
         ST_EXIT_IR:  seq_tms = 1'b1;
         ST_UPD_IR:   seq_tms = 1'b1;
         ST_SHIFT_DR: begin
            seq_tms = (cnt_q == len_m1_q);
            seq_tdi = dr_sh_q[0];
         end
         ST_EXIT_DR:  seq_tms = 1'b1;
         default:     seq_tms = 1'b0;
      endcase
   end

   assign bus.SEQ_TMS   = seq_tms;
   assign bus.SEQ_TDI   = seq_tdi;
   assign bus.REQ_READY = (state_q == ST_IDLE);
   assign bus.SEQ_BUSY  = (state_q != ST_IDLE);
   assign bus.RSP_VALID = rsp_vld_q;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
   assign bus.RSP_DATA  = rsp_dat_q;
`else
   assign bus.RSP_DATA  = 32'd0;
`endif

endmodule

// File: tb/tb_jtag_scan_seq.sv
// Bench for jtag_scan_seq: a behavioural 16-state TAP follows SEQ_TMS, supplies TDO
// and records TDI; a scoreboard queue holds the expected response of every accepted request.
module tb_jtag_scan_seq;

   logic clk = 1'b0;
   logic reset_N = 1'b0;
   always #5 clk = ~clk;

   jtag_scan_seq_if bif ();

   jtag_scan_seq dut (
      .JTAG_CLOCK (clk),
      .reset_N    (reset_N),
      .bus        (bif)
   );

   localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7,
                  UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

   typedef struct {
      int          lat;
      logic [31:0] rsp;
      logic [7:0]  ir;
      logic [31:0] dr;
      int          len;
      int          ir_len;
      logic [63:0] tms;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pat_q[$];

   int n_assert = 0;
   int n_fail   = 0;
   int n_rsp    = 0;
   int cyc      = 0;
   int last_rsp_cyc = -1;
   bit b2b_chk  = 1'b0;
   logic [31:0] drv_pat = 32'd0;

   // monitor / TAP-model state
   int          tap_st = TLR;
   bit          in_scan = 1'b0;
   logic [63:0] tms_hist = 64'd0;
   int          tms_n = 0;
   logic [7:0]  ir_bits = 8'd0;
   int          ir_n = 0;
   logic [31:0] dr_bits = 32'd0;
   int          dr_n = 0;
   logic [31:0] cur_pat = 32'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int tap_next(input int s, input logic tms);
      case (s)
         TLR:  return tms ? TLR  : RTI;
         RTI:  return tms ? SDR  : RTI;
         SDR:  return tms ? SIR  : CDR;
         CDR:  return tms ? E1DR : SHDR;
         SHDR: return tms ? E1DR : SHDR;
         E1DR: return tms ? UDR  : PDR;
         PDR:  return tms ? E2DR : PDR;
         E2DR: return tms ? UDR  : SHDR;
         UDR:  return tms ? SDR  : RTI;
         SIR:  return tms ? TLR  : CIR;
         CIR:  return tms ? E1IR : SHIR;
         SHIR: return tms ? E1IR : SHIR;
         E1IR: return tms ? UIR  : PIR;
         PIR:  return tms ? E2IR : PIR;
         E2IR: return tms ? UIR  : SHIR;
         default: return tms ? SDR : RTI;
      endcase
   endfunction

   // TMS expected from GO through UPD_DR, oldest bit most significant.
   function automatic logic [63:0] exp_tms(input bit skip, input int len);
      logic [63:0] v;
      v = skip ? 64'b100 : 64'b1100000011100;
      for (int i = 0; i < len; i++) v = {v[62:0], (i == len - 1)};
      v = {v[61:0], 2'b10};
      return v;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   nlen;
      logic [63:0] m;
      if (!reset_N) begin
         exp_q.delete();
         pat_q.delete();
         in_scan = 1'b0;
      end else begin
         if (bif.RSP_VALID) begin
            n_rsp++;
            last_rsp_cyc = cyc;
            in_scan = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_data", bif.RSP_DATA, e.rsp);
               chk("latency", cyc - e.acc - 1, e.lat);
               chk("tms_count", tms_n, e.lat);
               chk("tms_seq", tms_hist, e.tms);
               chk("ir_len", ir_n, e.ir_len);
               chk("ir_tdi", ir_bits, e.ir);
               chk("shift_dr_len", dr_n, e.len);
               chk("dr_tdi", dr_bits, e.dr);
               chk("tap_in_rti", tap_st, RTI);
            end
         end
         if (in_scan) begin
            tms_hist = {tms_hist[62:0], bif.SEQ_TMS};
            tms_n++;
         end
         if (bif.REQ_VALID && bif.REQ_READY) begin
            if (b2b_chk) begin
               chk("b2b_no_gap", cyc, last_rsp_cyc);
               b2b_chk = 1'b0;
            end
            nlen = (bif.REQ_DR_LEN == 0 || bif.REQ_DR_LEN > 32) ? 32 : int'(bif.REQ_DR_LEN);
            m = (64'd1 << nlen) - 64'd1;
            e.len    = nlen;
            e.lat    = bif.REQ_SKIP_IR ? 5 + nlen : 15 + nlen;
            e.ir_len = bif.REQ_SKIP_IR ? 0 : 5;
            e.ir     = bif.REQ_SKIP_IR ? 8'd0 : {3'd0, bif.REQ_IR};
            e.dr     = bif.REQ_DR_DATA & m[31:0];
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
            e.rsp    = drv_pat & m[31:0];
`else
            e.rsp    = 32'd0;
`endif
            e.tms    = exp_tms(bif.REQ_SKIP_IR, nlen);
            e.acc    = cyc;
            exp_q.push_back(e);
            pat_q.push_back(drv_pat);
            in_scan  = 1'b1;
            tms_hist = 64'd0;
            tms_n    = 0;
            ir_bits  = 8'd0;
            ir_n     = 0;
         end
      end
      // TAP model: tap_st is the state for the cycle now ending.
      bif.SEQ_TDO = 1'b0;
      if (tap_st == CDR) begin
         cur_pat = (pat_q.size() != 0) ? pat_q.pop_front() : 32'd0;
         dr_n    = 0;
         dr_bits = 32'd0;
      end
      if (tap_st == SHDR && dr_n < 32) begin
         bif.SEQ_TDO    = cur_pat[dr_n];
         dr_bits[dr_n]  = bif.SEQ_TDI;
         dr_n++;
      end
      if (tap_st == SHIR && ir_n < 8) begin
         ir_bits[ir_n] = bif.SEQ_TDI;
         ir_n++;
      end
      tap_st = tap_next(tap_st, bif.SEQ_TMS);
      cyc++;
   end

   task automatic chk_reset_vals();
      chk("rst_ready", bif.REQ_READY, 0);
      chk("rst_busy",  bif.SEQ_BUSY, 1);
      chk("rst_tms",   bif.SEQ_TMS, 1);
      chk("rst_tdi",   bif.SEQ_TDI, 0);
      chk("rst_rsp_valid", bif.RSP_VALID, 0);
      chk("rst_rsp_data",  bif.RSP_DATA, 0);
   endtask

   task automatic release_and_check_init();
      @(posedge clk); #1 reset_N = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("init_tms", bif.SEQ_TMS, (i < 5) ? 1 : 0);
         chk("init_ready_low", bif.REQ_READY, 0);
      end
      @(negedge clk);
      chk("init_ready", bif.REQ_READY, 1);
   endtask

   task automatic issue(input logic [4:0] ir, input bit skip, input logic [5:0] len,
                        input logic [31:0] data, input logic [31:0] pat, input bit hold);
      bit ok;
      @(posedge clk); #1;
      bif.REQ_IR      = ir;
      bif.REQ_SKIP_IR = skip;
      bif.REQ_DR_LEN  = len;
      bif.REQ_DR_DATA = data;
      drv_pat         = pat;
      bif.REQ_VALID   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bif.REQ_READY;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      if (!hold) bif.REQ_VALID = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      for (int i = 0; i < 200 && n_rsp < target; i++) @(negedge clk);
      #1 chk("rsp_arrived", n_rsp, target);
   endtask

   initial begin
      int saved;
      bit found;
      bif.REQ_VALID   = 1'b0;
      bif.REQ_IR      = 5'd0;
      bif.REQ_SKIP_IR = 1'b0;
      bif.REQ_DR_LEN  = 6'd0;
      bif.REQ_DR_DATA = 32'd0;
      bif.SEQ_TDO     = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals();
      release_and_check_init();

      // IDCODE-style read: IR=1, 32 bits
      issue(5'b00001, 1'b0, 6'd32, $urandom, 32'h1234_5679, 1'b0);
      wait_rsp(1);
      // DR only, single bit
      issue(5'h1f, 1'b1, 6'd1, 32'd1, 32'd0, 1'b0);
      wait_rsp(2);
      // length 0 -> 32, DR only
      issue(5'h0a, 1'b1, 6'd0, $urandom, $urandom, 1'b0);
      wait_rsp(3);
      // length 40 -> 32, with IR
      issue(5'h1a, 1'b0, 6'd40, $urandom, $urandom, 1'b0);
      wait_rsp(4);
      // short scan with IR
      issue(5'h15, 1'b0, 6'd7, $urandom, $urandom, 1'b0);
      wait_rsp(5);

      // back-to-back: the second request is presented while the first is busy
      issue(5'h03, 1'b0, 6'd12, $urandom, $urandom, 1'b1);
      b2b_chk = 1'b1;
      issue(5'h1c, 1'b1, 6'd5, $urandom, $urandom, 1'b0);
      wait_rsp(7);
      chk("b2b_seen", b2b_chk, 0);

      // reset in the middle of SHIFT_DR
      issue(5'h07, 1'b0, 6'd20, $urandom, $urandom, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         found = (tap_st == SHDR);
      end
      chk("reached_shift_dr", found, 1);
      repeat (3) @(negedge clk);
      saved = n_rsp;
      #2 reset_N = 1'b0;
      #1 chk_reset_vals();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals();
      release_and_check_init();
      repeat (30) @(negedge clk);
      chk("abort_no_rsp", n_rsp, saved);

      // recovery scan after the abort
      issue(5'h11, 1'b0, 6'd9, $urandom, $urandom, 1'b0);
      wait_rsp(8);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
